sync_fifo_param: RTL and testbench

//  Parametrised single-clock FIFO; next-generation replacement for the fixed 8-bit sync FIFO.

---
 rtl/sync_fifo_param.sv | 138 +++++++++++++
 tb/tb_sync_fifo_param.sv | 172 +++++++++++++++++
 2 files changed

// File: rtl/sync_fifo_param.sv
`default_nettype none
// ============================================================================
//  Module   : sync_fifo_param
//  Brief    : Parametrised single-clock FIFO with occupancy count and
//             programmable almost-full / almost-empty thresholds. Any DEPTH
//             >= 2 is supported (pointers wrap by explicit compare).
//             Optional macro SYNC_FIFO_ERR_FLAGS_EN adds sticky
//             overflow / underflow outputs.
//  Revision : 1.0 - initial release
// ============================================================================
module sync_fifo_param #(
    parameter int WIDTH     = 8,
    parameter int DEPTH     = 16,
    parameter int AF_THRESH = 14,
    parameter int AE_THRESH = 2,
    localparam int CW       = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] din,
    input  logic             wr,
    input  logic             rd,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty,
    output logic             almost_full,
    output logic             almost_empty,
`ifdef SYNC_FIFO_ERR_FLAGS_EN
    output logic             overflow,
    output logic             underflow,
`endif
    output logic [CW-1:0]    count
);

    localparam int            c_pw    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [c_pw-1:0] c_last  = c_pw'(DEPTH - 1);
    localparam logic [CW-1:0] c_depth = CW'(DEPTH);
    localparam logic [CW-1:0] c_af    = CW'(AF_THRESH);
    localparam logic [CW-1:0] c_ae    = CW'(AE_THRESH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [c_pw-1:0]  r_wr_ptr;
    logic [c_pw-1:0]  r_rd_ptr;
    logic [CW-1:0]    r_count;
    logic [WIDTH-1:0] r_dout;
    logic             r_full;
    logic             r_empty;
    logic             r_almost_full;
    logic             r_almost_empty;

    logic             w_wr_ok;
    logic             w_rd_ok;
    logic [CW-1:0]    w_count_nxt;
    logic [c_pw-1:0]  w_wr_ptr_inc;
    logic [c_pw-1:0]  w_rd_ptr_inc;

    // Accept decisions use only registered flags; a write at full is allowed
    // when a read frees the slot in the same cycle.
    always_comb begin
        w_wr_ok      = wr & (~r_full | rd);
        w_rd_ok      = rd & ~r_empty;
        w_wr_ptr_inc = (r_wr_ptr == c_last) ? '0 : r_wr_ptr + 1'b1;
        w_rd_ptr_inc = (r_rd_ptr == c_last) ? '0 : r_rd_ptr + 1'b1;
        w_count_nxt  = r_count;
        case ({w_wr_ok, w_rd_ok})
            2'b10:   w_count_nxt = r_count + 1'b1;
            2'b01:   w_count_nxt = r_count - 1'b1;
            default: w_count_nxt = r_count;
        endcase
    end

    // Storage array: written on accepted writes only, never cleared.
    always_ff @(posedge clk) begin
        if (w_wr_ok && rst_n) begin
            r_mem[r_wr_ptr] <= din;
        end
    end

    // Pointers, count, read data and flags; flags come from the next count
    // so they always line up with the count output.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_wr_ptr       <= '0;
            r_rd_ptr       <= '0;
            r_count        <= '0;
            r_dout         <= '0;
            r_full         <= 1'b0;
            r_empty        <= 1'b1;
            r_almost_full  <= 1'b0;
            r_almost_empty <= 1'b1;
        end else begin
            if (w_wr_ok) begin
                r_wr_ptr <= w_wr_ptr_inc;
            end
            if (w_rd_ok) begin
                r_rd_ptr <= w_rd_ptr_inc;
                r_dout   <= r_mem[r_rd_ptr];
            end
            r_count        <= w_count_nxt;
            r_full         <= (w_count_nxt == c_depth);
            r_empty        <= (w_count_nxt == '0);
            r_almost_full  <= (w_count_nxt >= c_af);
            r_almost_empty <= (w_count_nxt <= c_ae);
        end
    end

`ifdef SYNC_FIFO_ERR_FLAGS_EN
    logic r_overflow;
    logic r_underflow;

    // Sticky error flags: set on a dropped write or an ignored read.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_overflow  <= 1'b0;
            r_underflow <= 1'b0;
        end else begin
            if (wr && r_full && !rd) begin
                r_overflow <= 1'b1;
            end
            if (rd && r_empty) begin
                r_underflow <= 1'b1;
            end
        end
    end

    assign overflow  = r_overflow;
    assign underflow = r_underflow;
`endif

    assign dout         = r_dout;
    assign full         = r_full;
    assign empty        = r_empty;
    assign almost_full  = r_almost_full;
    assign almost_empty = r_almost_empty;
    assign count        = r_count;

endmodule
`default_nettype wire

// File: tb/tb_sync_fifo_param.sv
`default_nettype none
// ============================================================================
//  Module   : tb_sync_fifo_param
//  Brief    : Self-checking bench for sync_fifo_param. Two instances
//             (DEPTH=16 and DEPTH=5) are compared every cycle against
//             queue-based reference models, under directed and random
//             stimulus.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_sync_fifo_param;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [7:0] din_a = '0, din_b = '0;
    logic       wr_a = 1'b0, rd_a = 1'b0, wr_b = 1'b0, rd_b = 1'b0;
    logic [7:0] dout_a, dout_b;
    logic       full_a, empty_a, af_a, ae_a;
    logic       full_b, empty_b, af_b, ae_b;
    logic [4:0] count_a;
    logic [2:0] count_b;
`ifdef SYNC_FIFO_ERR_FLAGS_EN
    logic       ovf_a, unf_a, ovf_b, unf_b;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model state
    logic [7:0] qa[$];
    logic [7:0] qb[$];
    logic [7:0] ea_dout = '0, eb_dout = '0;
    bit         ea_ovf = 0, ea_unf = 0, eb_ovf = 0, eb_unf = 0;

    always #5 clk = ~clk;

    sync_fifo_param #(.WIDTH(8), .DEPTH(16), .AF_THRESH(14), .AE_THRESH(2)) u_dut_a (
        .clk(clk), .rst_n(rst_n), .din(din_a), .wr(wr_a), .rd(rd_a),
        .dout(dout_a), .full(full_a), .empty(empty_a),
        .almost_full(af_a), .almost_empty(ae_a),
`ifdef SYNC_FIFO_ERR_FLAGS_EN
        .overflow(ovf_a), .underflow(unf_a),
`endif
        .count(count_a)
    );

    sync_fifo_param #(.WIDTH(8), .DEPTH(5), .AF_THRESH(4), .AE_THRESH(1)) u_dut_b (
        .clk(clk), .rst_n(rst_n), .din(din_b), .wr(wr_b), .rd(rd_b),
        .dout(dout_b), .full(full_b), .empty(empty_b),
        .almost_full(af_b), .almost_empty(ae_b),
`ifdef SYNC_FIFO_ERR_FLAGS_EN
        .overflow(ovf_b), .underflow(unf_b),
`endif
        .count(count_b)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got=0x%0h expected=0x%0h at t=%0t", tag, got, exp, $time);
        end
    endtask

    // One clock: drive inputs at negedge, advance model at posedge, compare after.
    task automatic step(input logic rs, input logic wa, input logic ra, input logic [7:0] da,
                        input logic wb, input logic rb, input logic [7:0] db);
        bit wok, rok;
        int sz;
        @(negedge clk);
        rst_n = rs; wr_a = wa; rd_a = ra; din_a = da; wr_b = wb; rd_b = rb; din_b = db;
        @(posedge clk);
        if (!rs) begin
            qa.delete(); qb.delete();
            ea_dout = '0; eb_dout = '0;
            ea_ovf = 0; ea_unf = 0; eb_ovf = 0; eb_unf = 0;
        end else begin
            sz  = qa.size();
            wok = wa && (sz < 16 || ra);
            rok = ra && (sz > 0);
            if (wa && sz == 16 && !ra) ea_ovf = 1;
            if (ra && sz == 0) ea_unf = 1;
            if (rok) ea_dout = qa.pop_front();
            if (wok) qa.push_back(da);
            sz  = qb.size();
            wok = wb && (sz < 5 || rb);
            rok = rb && (sz > 0);
            if (wb && sz == 5 && !rb) eb_ovf = 1;
            if (rb && sz == 0) eb_unf = 1;
            if (rok) eb_dout = qb.pop_front();
            if (wok) qb.push_back(db);
        end
        #1;
        check("a_count", 32'(count_a), 32'(qa.size()));
        check("a_dout",  32'(dout_a),  32'(ea_dout));
        check("a_full",  32'(full_a),  32'(qa.size() == 16));
        check("a_empty", 32'(empty_a), 32'(qa.size() == 0));
        check("a_afull", 32'(af_a),    32'(qa.size() >= 14));
        check("a_aempty",32'(ae_a),    32'(qa.size() <= 2));
        check("b_count", 32'(count_b), 32'(qb.size()));
        check("b_dout",  32'(dout_b),  32'(eb_dout));
        check("b_full",  32'(full_b),  32'(qb.size() == 5));
        check("b_empty", 32'(empty_b), 32'(qb.size() == 0));
        check("b_afull", 32'(af_b),    32'(qb.size() >= 4));
        check("b_aempty",32'(ae_b),    32'(qb.size() <= 1));
`ifdef SYNC_FIFO_ERR_FLAGS_EN
        check("a_ovf", 32'(ovf_a), 32'(ea_ovf));
        check("a_unf", 32'(unf_a), 32'(ea_unf));
        check("b_ovf", 32'(ovf_b), 32'(eb_ovf));
        check("b_unf", 32'(unf_b), 32'(eb_unf));
`endif
    endtask

    task automatic step_a(input logic wa, input logic ra, input logic [7:0] da);
        step(1'b1, wa, ra, da, 1'b0, 1'b0, 8'h00);
    endtask

    initial begin
        int pw, pr;
        logic [7:0] d;

        // Reset held two cycles with writes requested: nothing may be stored.
        step(1'b0, 1'b1, 1'b0, 8'h3C, 1'b1, 1'b0, 8'hC3);
        step(1'b0, 1'b1, 1'b0, 8'h3D, 1'b1, 1'b0, 8'hC4);
        step_a(1'b0, 1'b0, 8'h00);

        // Fill 0x00..0x0F, then drain in order.
        for (int i = 0; i < 16; i++) step_a(1'b1, 1'b0, 8'(i));
        for (int i = 0; i < 16; i++) step_a(1'b0, 1'b1, 8'h00);

        // Simultaneous write/read at full: oldest out, 0xAA lands last.
        for (int i = 0; i < 16; i++) step_a(1'b1, 1'b0, 8'(8'h10 + i));
        step_a(1'b1, 1'b1, 8'hAA);
        for (int i = 0; i < 16; i++) step_a(1'b0, 1'b1, 8'h00);

        // Simultaneous write/read at empty: write only, then read 0x55.
        step_a(1'b1, 1'b1, 8'h55);
        step_a(1'b0, 1'b1, 8'h00);

        // Wrap on the depth-5 instance: 3 writes then 3 reads, four rounds.
        for (int r = 0; r < 4; r++) begin
            for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 8'(r * 16 + i + 1));
            for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 8'h00);
        end

        // Dropped write at full and ignored read at empty, then sticky hold.
        for (int i = 0; i < 16; i++) step_a(1'b1, 1'b0, 8'(8'h80 + i));
        step_a(1'b1, 1'b0, 8'hEE);
        step_a(1'b0, 1'b0, 8'h00);
        for (int i = 0; i < 16; i++) step_a(1'b0, 1'b1, 8'h00);
        step_a(1'b0, 1'b1, 8'h00);
        step_a(1'b0, 1'b0, 8'h00);
        step(1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 8'h00);

        // Random traffic with phases biased toward full, empty and balanced.
        for (int i = 0; i < 3000; i++) begin
            case ((i / 150) % 3)
                0:       begin pw = 80; pr = 30; end
                1:       begin pw = 30; pr = 80; end
                default: begin pw = 55; pr = 55; end
            endcase
            d = 8'($urandom);
            step(($urandom_range(399) != 0),
                 ($urandom_range(99) < pw), ($urandom_range(99) < pr), d,
                 ($urandom_range(99) < pw), ($urandom_range(99) < pr), 8'($urandom));
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
